// File: rtl/sa_skew_feeder.sv
// Input skew and tile-boundary token generator for the square systolic kernel.
// Delays each A row / B column lane by its distance from PE(SIZE,SIZE) and times the per-PE finish strobes.
module sa_skew_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int SIZE       = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [SIZE*DATA_WIDTH-1:0]   in_a,
  input  logic [SIZE*DATA_WIDTH-1:0]   in_b,
  output logic [SIZE*DATA_WIDTH-1:0]   out_left,
  output logic [SIZE*DATA_WIDTH-1:0]   out_up,
  output logic [SIZE*SIZE-1:0]         finish,
  output logic                         tile_done,
  output logic [15:0]                  tile_count,
  output logic                         busy
);

  localparam int DW   = DATA_WIDTH;
  localparam int TAPS = 2*SIZE-1;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t          state;
  logic            accept;
  logic            last_q;
  logic            real_q;
  logic            open_tile;
  logic [TAPS-1:0] tok;
  logic [TAPS-1:0] tok_real;

  assign in_ready = (state == ST_RUN) & ~rst;
  assign accept   = in_valid & in_ready;

  // The cycle spent in ST_FLUSH launches a non-real token that clears stale PE sums.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FLUSH;
      last_q     <= 1'b0;
      real_q     <= 1'b0;
      open_tile  <= 1'b0;
      tok        <= '0;
      tok_real   <= '0;
      tile_done  <= 1'b0;
      tile_count <= '0;
    end else begin
      state     <= ST_RUN;
      last_q    <= (accept & in_last) | (state == ST_FLUSH);
      real_q    <= accept & in_last;
      tok       <= {tok[TAPS-2:0], last_q};
      tok_real  <= {tok_real[TAPS-2:0], real_q};
      tile_done <= tok[TAPS-1] & tok_real[TAPS-1];
      if (tok[TAPS-1] & tok_real[TAPS-1]) begin
        tile_count <= tile_count + 16'd1;
      end
      if (accept) begin
        open_tile <= ~in_last;
      end
    end
  end

  assign busy = open_tile | real_q | (|tok_real) | tile_done;

  // Lane l serves row/column index l+1 and needs SIZE-l registers.
  for (genvar l = 0; l < SIZE; l++) begin : g_lane
    localparam int DEPTH = SIZE - l;
    logic [DW-1:0] a_pipe [DEPTH];
    logic [DW-1:0] b_pipe [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < DEPTH; s++) begin
          a_pipe[s] <= '0;
          b_pipe[s] <= '0;
        end
      end else begin
        a_pipe[0] <= accept ? in_a[l*DW +: DW] : '0;
        b_pipe[0] <= accept ? in_b[l*DW +: DW] : '0;
        for (int s = 1; s < DEPTH; s++) begin
          a_pipe[s] <= a_pipe[s-1];
          b_pipe[s] <= b_pipe[s-1];
        end
      end
    end

    assign out_left[l*DW +: DW] = a_pipe[DEPTH-1];
    assign out_up[l*DW +: DW]   = b_pipe[DEPTH-1];
  end

  // PE(i,j) sits (SIZE-i)+(SIZE-j) hops from the corner that sees the token first.
  for (genvar i = 1; i <= SIZE; i++) begin : g_row
    for (genvar j = 1; j <= SIZE; j++) begin : g_col
      assign finish[(i-1)*SIZE + j-1] = tok[2*SIZE-i-j];
    end
  end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Self-checking bench for sa_skew_feeder: cycle-level reference model plus an idealised PE array.
module tb_sa_skew_feeder;

  localparam int S    = 4;
  localparam int DW   = 16;
  localparam int W    = S*DW;
  localparam int MAXC = 2000;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic           in_last;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic [W-1:0]   out_left;
  logic [W-1:0]   out_up;
  logic [S*S-1:0] finish;
  logic           tile_done;
  logic [15:0]    tile_count;
  logic           busy;

  sa_skew_feeder #(.DATA_WIDTH(DW), .SIZE(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_left   (out_left),
    .out_up     (out_up),
    .finish     (finish),
    .tile_done  (tile_done),
    .tile_count (tile_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle history of stimulus and DUT lane outputs
  logic         rst_h [MAXC];
  logic         acc_h [MAXC];
  logic         last_h[MAXC];
  logic [W-1:0] a_h   [MAXC];
  logic [W-1:0] b_h   [MAXC];
  logic [W-1:0] dl_h  [MAXC];
  logic [W-1:0] du_h  [MAXC];
  int           last_rst  = -1;
  logic [15:0]  exp_count = 16'd0;

  logic [15:0] pe_acc[1:S][1:S];
  logic [15:0] pe_res[1:S][1:S];
  int          ncap  [1:S][1:S];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d got=%h want=%h", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic l,
                               input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #1;
    rst = r; in_valid = v; in_last = l; in_a = a; in_b = b;
  endtask

  function automatic logic [W-1:0] rep(input logic [15:0] x);
    return {S{x}};
  endfunction

  function automatic logic src_real(input int s);
    if (s < 0) return 1'b0;
    return acc_h[s] && last_h[s];
  endfunction

  function automatic logic src_any(input int s);
    if (s < 1) return 1'b0;
    return src_real(s) || (rst_h[s-1] && !rst_h[s]);
  endfunction

  // Reference model: everything derived from when beats were accepted and when resets occurred.
  task automatic modelCycle();
    int t = cyc;
    logic exp_rdy, ed, eb, found, f;
    logic [W-1:0] el, eu;
    logic [S*S-1:0] ef;
    logic [15:0] lv, uv;
    logic signed [31:0] p;
    int c, s, idx;
    if (t >= MAXC) return;
    rst_h[t] = rst; last_h[t] = in_last; a_h[t] = in_a; b_h[t] = in_b;
    dl_h[t]  = out_left; du_h[t] = out_up;
    exp_rdy  = !rst && (t >= 1) && !rst_h[(t >= 1) ? t-1 : 0];
    acc_h[t] = in_valid && exp_rdy;
    if (last_rst >= 0) begin
      checkOutput("in_ready", 64'(in_ready), 64'(exp_rdy));
      el = '0; eu = '0; ef = '0;
      for (int i = 1; i <= S; i++) begin
        c = t-1-(S-i);
        if (c > last_rst && acc_h[c]) begin
          el[i*DW-1 -: DW] = a_h[c][i*DW-1 -: DW];
          eu[i*DW-1 -: DW] = b_h[c][i*DW-1 -: DW];
        end
      end
      checkOutput("out_left", out_left, el);
      checkOutput("out_up", out_up, eu);
      for (int i = 1; i <= S; i++)
        for (int j = 1; j <= S; j++) begin
          s = t-2-(2*S-i-j);
          ef[(i-1)*S+j-1] = (s > last_rst) && src_any(s);
        end
      checkOutput("finish", 64'(finish), 64'(ef));
      s  = t-2*S-1;
      ed = (s > last_rst) && src_real(s);
      checkOutput("tile_done", 64'(tile_done), 64'(ed));
      if (last_rst == t-1) exp_count = 16'd0;
      if (ed) exp_count = exp_count + 16'd1;
      checkOutput("tile_count", 64'(tile_count), 64'(exp_count));
      found = 1'b0; eb = 1'b0;
      for (int k = t-1; k > last_rst && !found; k--) begin
        if (acc_h[k]) begin
          found = 1'b1;
          eb = !last_h[k] || (t <= k+2*S+1);
        end
      end
      checkOutput("busy", 64'(busy), 64'(eb));
      // Idealised kernel: operands hop one PE per cycle rightward/downward from the DUT lanes
      for (int i = 1; i <= S; i++)
        for (int j = 1; j <= S; j++) begin
          idx = t-(S-j);
          lv = (idx >= 0) ? dl_h[idx][i*DW-1 -: DW] : 16'd0;
          idx = t-(S-i);
          uv = (idx >= 0) ? du_h[idx][j*DW-1 -: DW] : 16'd0;
          p = $signed(lv) * $signed(uv);
          p = p >>> 8;
          f = finish[(i-1)*S+j-1];
          if (f) begin
            pe_res[i][j] = pe_acc[i][j];
            pe_acc[i][j] = p[15:0];
          end else begin
            pe_acc[i][j] = pe_acc[i][j] + p[15:0];
          end
        end
    end
    if (rst) last_rst = t;
  endtask

  always @(negedge clk) modelCycle();

  task automatic waitDone(output int done_cyc, output logic found);
    found = 1'b0; done_cyc = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk); #1;
      if (tile_done) begin
        found = 1'b1; done_cyc = cyc;
        break;
      end
      applyStimulus(0, 0, 0, '0, '0);
    end
  endtask

  typedef struct {
    int          nbeats;
    int          bub_at;
    int          bub_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    int          span;
  } vec_t;

  vec_t vecs[4];
  int   first, lastc, dc, l1, l2, d1, d2, ndone, exp_tiles;
  logic found;
  logic [W-1:0] skew_l[1:5];
  logic [W-1:0] skew_u[1:5];

  initial begin
    vecs[0] = '{3, -1, 0, 16'h0100, 16'h0100, 16'h0300, 11};
    vecs[1] = '{3,  0, 2, 16'h0100, 16'h0100, 16'h0300, 13};
    vecs[2] = '{1, -1, 0, 16'h0200, 16'h0180, 16'h0300, 9};
    vecs[3] = '{4, -1, 0, 16'hFF00, 16'h0080, 16'hFE00, 12};
    skew_l[1] = 64'h0004_0000_0000_0000; skew_u[1] = 64'h0008_0000_0000_0000;
    skew_l[2] = 64'h0000_0003_0000_0000; skew_u[2] = 64'h0000_0007_0000_0000;
    skew_l[3] = 64'h0000_0000_0002_0000; skew_u[3] = 64'h0000_0000_0006_0000;
    skew_l[4] = 64'h0000_0000_0000_0001; skew_u[4] = 64'h0000_0000_0000_0005;
    skew_l[5] = '0;                      skew_u[5] = '0;
    for (int i = 1; i <= S; i++)
      for (int j = 1; j <= S; j++) begin
        pe_acc[i][j] = '0; pe_res[i][j] = '0; ncap[i][j] = 0;
      end
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0;

    // Reset release and flush token sweep
    applyStimulus(1, 0, 0, '0, '0);
    applyStimulus(1, 0, 0, '0, '0);
    applyStimulus(0, 0, 0, '0, '0);
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) applyStimulus(0, 0, 0, '0, '0);
      @(negedge clk); #1;
      if (k == 0) checkOutput("ready_R", 64'(in_ready), 64'd0);
      if (k == 1) checkOutput("ready_R1", 64'(in_ready), 64'd1);
      if (k == 2) checkOutput("flush_R2", 64'(finish), 64'h8000);
      if (k == 5) checkOutput("flush_R5", 64'(finish), 64'h1248);
      if (k == 8) checkOutput("flush_R8", 64'(finish), 64'h0001);
      checkOutput("flush_done", 64'(tile_done), 64'd0);
    end

    // Single beat with distinct lane values shows the per-lane skew
    applyStimulus(0, 1, 1, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(0, 0, 0, '0, '0);
      @(negedge clk); #1;
      checkOutput("skew_left", out_left, skew_l[k]);
      checkOutput("skew_up", out_up, skew_u[k]);
    end
    waitDone(dc, found);
    exp_tiles = 1;
    checkOutput("skew_done", 64'(found), 64'd1);
    checkOutput("skew_count", 64'(tile_count), 64'(exp_tiles));

    // Table-driven tiles
    for (int v = 0; v < 4; v++) begin
      first = -1; lastc = -1;
      for (int k = 0; k < vecs[v].nbeats; k++) begin
        applyStimulus(0, 1, k == vecs[v].nbeats-1, rep(vecs[v].a), rep(vecs[v].b));
        if (k == 0) first = cyc;
        if (k == vecs[v].nbeats-1) lastc = cyc;
        if (k == vecs[v].bub_at)
          for (int q = 0; q < vecs[v].bub_n; q++) applyStimulus(0, 0, 0, '0, '0);
      end
      waitDone(dc, found);
      exp_tiles++;
      checkOutput("tbl_found", 64'(found), 64'd1);
      checkOutput("tbl_latency", 64'(dc-lastc), 64'(2*S+1));
      checkOutput("tbl_span", 64'(dc-first), 64'(vecs[v].span));
      checkOutput("tbl_count", 64'(tile_count), 64'(exp_tiles));
      for (int i = 1; i <= S; i++)
        for (int j = 1; j <= S; j++)
          checkOutput("tbl_result", 64'(pe_res[i][j]), 64'(vecs[v].res));
    end

    // Two 2-beat tiles back to back: every PE must capture 0x0200 then 0x0400
    applyStimulus(0, 1, 0, rep(16'h0100), rep(16'h0100));
    applyStimulus(0, 1, 1, rep(16'h0100), rep(16'h0100)); l1 = cyc;
    applyStimulus(0, 1, 0, rep(16'h0200), rep(16'h0100));
    applyStimulus(0, 1, 1, rep(16'h0200), rep(16'h0100)); l2 = cyc;
    ndone = 0; d1 = -1; d2 = -1;
    for (int n = 0; n < 30; n++) begin
      if (n > 0) applyStimulus(0, 0, 0, '0, '0);
      @(negedge clk); #1;
      if (tile_done) begin
        ndone++;
        if (ndone == 1) d1 = cyc; else d2 = cyc;
      end
      for (int i = 1; i <= S; i++)
        for (int j = 1; j <= S; j++)
          if (finish[(i-1)*S+j-1]) begin
            ncap[i][j]++;
            checkOutput("b2b_capture", 64'(pe_res[i][j]),
                        (ncap[i][j] == 1) ? 64'h0200 : 64'h0400);
          end
    end
    checkOutput("b2b_ndone", 64'(ndone), 64'd2);
    checkOutput("b2b_lat1", 64'(d1-l1), 64'(2*S+1));
    checkOutput("b2b_lat2", 64'(d2-l2), 64'(2*S+1));
    for (int i = 1; i <= S; i++)
      for (int j = 1; j <= S; j++)
        checkOutput("b2b_ncap", 64'(ncap[i][j]), 64'd2);

    // Reset after beat 2 of 3, then a 1-beat tile right after the flush cycle
    applyStimulus(0, 1, 0, rep(16'h0100), rep(16'h0100));
    applyStimulus(0, 1, 0, rep(16'h0100), rep(16'h0100));
    applyStimulus(1, 0, 0, '0, '0);
    applyStimulus(0, 0, 0, '0, '0);
    applyStimulus(0, 1, 1, rep(16'h0100), rep(16'h0100)); l1 = cyc;
    ndone = 0; d1 = -1;
    for (int n = 0; n < 30; n++) begin
      applyStimulus(0, 0, 0, '0, '0);
      @(negedge clk); #1;
      if (tile_done) begin
        ndone++;
        d1 = cyc;
        checkOutput("rst_count", 64'(tile_count), 64'd1);
        for (int i = 1; i <= S; i++)
          for (int j = 1; j <= S; j++)
            checkOutput("rst_result", 64'(pe_res[i][j]), 64'h0100);
      end
    end
    checkOutput("rst_ndone", 64'(ndone), 64'd1);
    checkOutput("rst_latency", 64'(d1-l1), 64'(2*S+1));

    // Randomised traffic with occasional resets, checked by the background model
    for (int n = 0; n < 800; n++) begin
      applyStimulus($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) == 0, {$urandom, $urandom}, {$urandom, $urandom});
    end
    for (int n = 0; n < 30; n++) applyStimulus(0, 0, 0, '0, '0);
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "[TB] timeout");
  end

endmodule
